// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Contents: the FSM state enum, the table update opcode, the counter reset value
// and width-generic saturating increment/decrement helpers.
package gshare_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    OP_INIT,
    OP_INC,
    OP_DEC
  } upd_op_e;

  // Weakly-not-taken: MSB clear, all lower bits set (01 for 2-bit counters).
  function automatic logic [31:0] ctr_init_val(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Helpers work on a 32-bit carrier; callers cast the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of 2**IDX_W saturating counters, CTR_W bits each.
// Ports:
//   clk_i                      clock, rising edge
//   rd_idx_i / rd_ctr_o        asynchronous read port (prediction)
//   upd_en_i, upd_idx_i,       read-modify-write port: init, saturating increment
//   upd_op_i                   or saturating decrement of entry upd_idx_i
// Contents are deliberately not reset; the owner clears them with OP_INIT writes.
module sat_counter_table
  import gshare_pkg::*;
#(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CTR_W-1:0] rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  upd_op_e          upd_op_i
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [CTR_W-1:0] mem_q [Depth];
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_new;

  assign rd_ctr_o = mem_q[rd_idx_i];
  assign upd_cur  = mem_q[upd_idx_i];

  always_comb begin
    upd_new = upd_cur;
    case (upd_op_i)
      OP_INIT: upd_new = CTR_W'(ctr_init_val(CTR_W));
      OP_INC:  upd_new = CTR_W'(sat_inc(32'(upd_cur), CTR_W));
      OP_DEC:  upd_new = CTR_W'(sat_dec(32'(upd_cur)));
      default: upd_new = upd_cur;
    endcase
  end

  // Write lands on the edge, so a same-cycle read still sees the old value.
  always_ff @(posedge clk_i) begin
    if (upd_en_i) begin
      mem_q[upd_idx_i] <= upd_new;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history (gshare) or bimodal branch predictor with registered predictions.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   ready                      high once the post-reset table clear has finished
//   req_valid, req_pc          prediction request from fetch
//   pred_valid/taken/idx       registered prediction, one cycle after the request
//   res_valid/idx/taken/mispred branch resolution; trains entry res_idx
//   perf_lookups/mispreds      saturating event counters
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned HIST_W = 10,
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned GSHARE = 1,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              req_valid,
  input  logic [PC_W-1:0]   req_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              res_valid,
  input  logic [IDX_W-1:0]  res_idx,
  input  logic              res_taken,
  input  logic              res_mispred,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_mispreds
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic                pred_valid_q, pred_valid_d;
  logic                pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0]    pred_idx_q, pred_idx_d;
  logic [PERF_W-1:0]   lookups_q, lookups_d;
  logic [PERF_W-1:0]   mispreds_q, mispreds_d;

  logic [IDX_W-1:0]    pc_bits;
  logic [IDX_W-1:0]    hist_ext;
  logic [IDX_W-1:0]    req_idx;
  logic [CTR_W-1:0]    rd_ctr;
  logic                upd_en;
  logic [IDX_W-1:0]    upd_idx;
  upd_op_e             upd_op;
  logic                run;
  logic                req_acc;
  logic                res_acc;
  logic                unused_pc;

  // Word-aligned PC: low two bits and bits above the index never affect lookup.
  assign pc_bits   = req_pc[IDX_W+1:2];
  assign unused_pc = ^{req_pc[PC_W-1:IDX_W+2], req_pc[1:0]};

  always_comb begin
    hist_ext               = '0;
    hist_ext[HIST_W-1:0]   = hist_q;
  end

  // Uses the pre-update history even when a result arrives in the same cycle.
  assign req_idx = (GSHARE != 0) ? (pc_bits ^ hist_ext) : pc_bits;

  assign run     = (state_q == ST_RUN);
  assign req_acc = run && req_valid;
  assign res_acc = run && res_valid;

  sat_counter_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_table (
    .clk_i     (clk),
    .rd_idx_i  (req_idx),
    .rd_ctr_o  (rd_ctr),
    .upd_en_i  (upd_en),
    .upd_idx_i (upd_idx),
    .upd_op_i  (upd_op)
  );

  // FSM and single table write port: INIT sweep and training never overlap.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    upd_en  = 1'b0;
    upd_idx = res_idx;
    upd_op  = res_taken ? OP_INC : OP_DEC;
    if (state_q == ST_INIT) begin
      upd_en  = 1'b1;
      upd_idx = ptr_q;
      upd_op  = OP_INIT;
      ptr_d   = ptr_q + IDX_W'(1);
      if (ptr_q == '1) begin
        state_d = ST_RUN;
      end
    end else begin
      upd_en = res_valid;
    end
  end

  always_comb begin
    hist_d       = hist_q;
    pred_valid_d = req_acc;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    lookups_d    = lookups_q;
    mispreds_d   = mispreds_q;
    if (req_acc) begin
      pred_taken_d = rd_ctr[CTR_W-1];
      pred_idx_d   = req_idx;
      if (lookups_q != '1) begin
        lookups_d = lookups_q + PERF_W'(1);
      end
    end
    if (res_acc) begin
      // Newest outcome enters at the LSB; the cast drops the oldest bit.
      hist_d = HIST_W'({hist_q, res_taken});
      if (res_mispred && (mispreds_q != '1)) begin
        mispreds_d = mispreds_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      hist_q       <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
      lookups_q    <= '0;
      mispreds_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hist_q       <= hist_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
      lookups_q    <= lookups_d;
      mispreds_q   <= mispreds_d;
    end
  end

  assign ready         = run;
  assign pred_valid    = pred_valid_q;
  assign pred_taken    = pred_taken_q;
  assign pred_idx      = pred_idx_q;
  assign perf_lookups  = lookups_q;
  assign perf_mispreds = mispreds_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: a gshare instance and a bimodal instance share one stimulus bus.
module tb_gshare_predictor;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        res_valid;
  logic [3:0]  res_idx;
  logic        res_taken;
  logic        res_mispred;

  logic       g_ready, g_pred_valid, g_pred_taken;
  logic [3:0] g_pred_idx, g_lookups, g_mispreds;
  logic       b_ready, b_pred_valid, b_pred_taken;
  logic [3:0] b_pred_idx, b_lookups, b_mispreds;

  int tests;
  int fails;

  gshare_predictor #(
    .PC_W (32), .IDX_W (4), .HIST_W (4), .CTR_W (2), .GSHARE (1), .PERF_W (4)
  ) dut_g (
    .clk (clk), .rst_n (rst_n), .ready (g_ready),
    .req_valid (req_valid), .req_pc (req_pc),
    .pred_valid (g_pred_valid), .pred_taken (g_pred_taken), .pred_idx (g_pred_idx),
    .res_valid (res_valid), .res_idx (res_idx), .res_taken (res_taken),
    .res_mispred (res_mispred),
    .perf_lookups (g_lookups), .perf_mispreds (g_mispreds)
  );

  gshare_predictor #(
    .PC_W (32), .IDX_W (4), .HIST_W (4), .CTR_W (2), .GSHARE (0), .PERF_W (4)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .ready (b_ready),
    .req_valid (req_valid), .req_pc (req_pc),
    .pred_valid (b_pred_valid), .pred_taken (b_pred_taken), .pred_idx (b_pred_idx),
    .res_valid (res_valid), .res_idx (res_idx), .res_taken (res_taken),
    .res_mispred (res_mispred),
    .perf_lookups (b_lookups), .perf_mispreds (b_mispreds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid   = 1'b0;
    req_pc      = '0;
    res_valid   = 1'b0;
    res_idx     = '0;
    res_taken   = 1'b0;
    res_mispred = 1'b0;
  endtask

  task automatic send_req(input logic [31:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_res(input logic [3:0] idx, input logic taken, input logic mp);
    res_valid   = 1'b1;
    res_idx     = idx;
    res_taken   = taken;
    res_mispred = mp;
    tick();
    res_valid   = 1'b0;
    res_mispred = 1'b0;
  endtask

  // Holds reset for two cycles, releases it, then waits (bounded) for both instances.
  task automatic do_reset(output int cycles);
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n  = 1'b1;
    cycles = 0;
    while (!(g_ready && b_ready) && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset;
    int cycles;
    bit pv_seen;
    clear_inputs();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (g_ready !== 1'b0 || g_pred_valid !== 1'b0 || g_pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b pred_valid=%b pred_taken=%b, required 0 0 0",
               g_ready, g_pred_valid, g_pred_taken);
    end
    tests++;
    if (g_pred_idx !== 4'h0 || g_lookups !== 4'h0 || g_mispreds !== 4'h0) begin
      fails++;
      $display("FAIL reset_data: pred_idx=%h lookups=%h mispreds=%h, required 0 0 0",
               g_pred_idx, g_lookups, g_mispreds);
    end
    repeat (2) tick();
    // Traffic during the sweep must be ignored.
    req_valid   = 1'b1;
    req_pc      = 32'h14;
    res_valid   = 1'b1;
    res_idx     = 4'h0;
    res_taken   = 1'b1;
    res_mispred = 1'b1;
    rst_n       = 1'b1;
    cycles      = 0;
    pv_seen     = 1'b0;
    while (!g_ready && cycles < 100) begin
      tick();
      cycles++;
      if (g_pred_valid) pv_seen = 1'b1;
    end
    clear_inputs();
    tests++;
    if (cycles != 16) begin
      fails++;
      $display("FAIL init_len: ready after %0d cycles, required 16", cycles);
    end
    tests++;
    if (pv_seen || g_lookups !== 4'h0 || g_mispreds !== 4'h0) begin
      fails++;
      $display("FAIL init_ignore: pred_valid_seen=%b lookups=%h mispreds=%h, required 0 0 0",
               pv_seen, g_lookups, g_mispreds);
    end
    send_req(32'h0);
    tests++;
    if (g_pred_valid !== 1'b1 || g_pred_taken !== 1'b0 || g_pred_idx !== 4'h0) begin
      fails++;
      $display("FAIL first_pred: valid=%b taken=%b idx=%h, required 1 0 0",
               g_pred_valid, g_pred_taken, g_pred_idx);
    end
    tick();
    tests++;
    if (g_pred_valid !== 1'b0) begin
      fails++;
      $display("FAIL pred_pulse: pred_valid=%b, required 0", g_pred_valid);
    end
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_pc = 32'(i * 4);
      tick();
      tests++;
      if (g_pred_valid !== 1'b1 || g_pred_idx !== 4'(i)) begin
        fails++;
        $display("FAIL b2b_%0d: valid=%b idx=%h, required 1 %h", i, g_pred_valid,
                 g_pred_idx, 4'(i));
      end
    end
    req_valid = 1'b0;
    tick();
    tests++;
    if (g_pred_valid !== 1'b0 || g_lookups !== 4'd5) begin
      fails++;
      $display("FAIL b2b_end: valid=%b lookups=%0d, required 0 5", g_pred_valid, g_lookups);
    end
  endtask

  task automatic test_bimodal;
    int cycles;
    do_reset(cycles);
    repeat (4) send_res(4'h3, 1'b1, 1'b0);
    send_req(32'hC);
    tests++;
    if (b_pred_taken !== 1'b1 || b_pred_idx !== 4'h3) begin
      fails++;
      $display("FAIL bimodal_sat_hi: taken=%b idx=%h, required 1 3", b_pred_taken, b_pred_idx);
    end
    repeat (5) send_res(4'h3, 1'b0, 1'b0);
    send_res(4'h3, 1'b1, 1'b0);
    send_req(32'hC);
    tests++;
    if (b_pred_taken !== 1'b0 || b_pred_idx !== 4'h3) begin
      fails++;
      $display("FAIL bimodal_sat_lo: taken=%b idx=%h, required 0 3", b_pred_taken, b_pred_idx);
    end
    tests++;
    if (b_lookups !== 4'd2 || b_mispreds !== 4'd0) begin
      fails++;
      $display("FAIL bimodal_perf: lookups=%0d mispreds=%0d, required 2 0",
               b_lookups, b_mispreds);
    end
  endtask

  task automatic test_gshare_hash;
    int cycles;
    do_reset(cycles);
    send_res(4'h0, 1'b1, 1'b0);
    send_res(4'h0, 1'b1, 1'b0);
    send_res(4'h0, 1'b0, 1'b0);
    send_res(4'h0, 1'b1, 1'b0);
    send_req(32'h8);
    tests++;
    if (g_pred_idx !== 4'hF || g_pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL gshare_hash: idx=%h taken=%b, required f 0", g_pred_idx, g_pred_taken);
    end
    tests++;
    if (b_pred_idx !== 4'h2) begin
      fails++;
      $display("FAIL bimodal_hash: idx=%h, required 2", b_pred_idx);
    end
  endtask

  task automatic test_conflict;
    int cycles;
    do_reset(cycles);
    req_valid = 1'b1;
    req_pc    = 32'h14;
    res_valid = 1'b1;
    res_idx   = 4'h5;
    res_taken = 1'b1;
    tick();
    clear_inputs();
    tests++;
    if (g_pred_taken !== 1'b0 || g_pred_idx !== 4'h5) begin
      fails++;
      $display("FAIL conflict_same: taken=%b idx=%h, required 0 5", g_pred_taken, g_pred_idx);
    end
    // History is now 0001, so pc_bits 4 lands on entry 5 again.
    send_req(32'h10);
    tests++;
    if (g_pred_taken !== 1'b1 || g_pred_idx !== 4'h5) begin
      fails++;
      $display("FAIL conflict_next: taken=%b idx=%h, required 1 5", g_pred_taken, g_pred_idx);
    end
  endtask

  task automatic test_perf;
    int cycles;
    do_reset(cycles);
    req_valid   = 1'b1;
    res_valid   = 1'b1;
    res_idx     = 4'h7;
    res_taken   = 1'b1;
    res_mispred = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_pc = 32'(i * 4);
      tick();
      if (i == 13) begin
        tests++;
        if (g_lookups !== 4'd14 || g_mispreds !== 4'd14) begin
          fails++;
          $display("FAIL perf_mid: lookups=%0d mispreds=%0d, required 14 14",
                   g_lookups, g_mispreds);
        end
      end
    end
    clear_inputs();
    tests++;
    if (g_lookups !== 4'd15 || g_mispreds !== 4'd15) begin
      fails++;
      $display("FAIL perf_sat: lookups=%0d mispreds=%0d, required 15 15", g_lookups, g_mispreds);
    end
  endtask

  task automatic test_reset_mid;
    int cycles;
    // History is 1111 after the perf run; pc_bits 8 maps to the trained entry 7.
    send_req(32'h20);
    tests++;
    if (g_pred_idx !== 4'h7 || g_pred_taken !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: idx=%h taken=%b, required 7 1", g_pred_idx, g_pred_taken);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (g_ready !== 1'b0 || g_lookups !== 4'd0 || g_mispreds !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset: ready=%b lookups=%0d mispreds=%0d, required 0 0 0",
               g_ready, g_lookups, g_mispreds);
    end
    repeat (2) tick();
    rst_n  = 1'b1;
    cycles = 0;
    while (!g_ready && cycles < 100) begin
      tick();
      cycles++;
    end
    tests++;
    if (cycles != 16) begin
      fails++;
      $display("FAIL mid_init_len: ready after %0d cycles, required 16", cycles);
    end
    for (int i = 0; i < 16; i++) begin
      send_req(32'(i * 4));
      tests++;
      if (g_pred_idx !== 4'(i) || g_pred_taken !== 1'b0) begin
        fails++;
        $display("FAIL cleared_%0d: idx=%h taken=%b, required %h 0", i, g_pred_idx,
                 g_pred_taken, 4'(i));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_inputs();
    rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_bimodal();
    test_gshare_hash();
    test_conflict();
    test_perf();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
